// File: rtl/incdec_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : incdec_pipe_if
// Purpose  : Request and result handshake bundle for incdec_pipe.
//            master = requester / result consumer, slave = incdec_pipe.
// Signals  : in_valid/in_ready, op[1:0], sel, A, B, step   (request side)
//            out_valid/out_ready, S, N, Z, Co, V           (result side)
// Revision : 1.0 - initial release
// ============================================================================
interface incdec_pipe_if #(
  parameter int BITS = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic            sel;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [BITS-1:0] step;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] S;
  logic            N;
  logic            Z;
  logic            Co;
  logic            V;

  modport master (
    output in_valid, op, sel, A, B, step, out_ready,
    input  in_ready, out_valid, S, N, Z, Co, V
  );

  modport slave (
    input  in_valid, op, sel, A, B, step, out_ready,
    output in_ready, out_valid, S, N, Z, Co, V
  );
endinterface
`default_nettype wire

// File: rtl/incdec_pipe.sv
`default_nettype none
// ============================================================================
// Module   : incdec_pipe
// Purpose  : Registered increment / decrement / accumulate unit with an
//            internal accumulator and a DEPTH-entry result FIFO. Results and
//            their flags are computed in the accept cycle and written into the
//            FIFO on the accept edge.
// Ports    : clk      rising-edge clock
//            rst_n    asynchronous active-low reset
//            bus      incdec_pipe_if.slave (request + result handshakes)
// Params   : BITS  datapath width (>= 2), DEPTH FIFO entries (power of 2, >= 1)
// Options  : INCDEC_SAT_EN - when defined, overflowing results clamp to the
//            signed max (INC/ACC) or min (DEC) instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module incdec_pipe #(
  parameter int BITS  = 4,
  parameter int DEPTH = 2
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  incdec_pipe_if.slave bus
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_EW = BITS + 4;   // entry = {S, N, Z, Co, V}

  localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

  localparam logic [1:0] c_OP_INC = 2'b00;
  localparam logic [1:0] c_OP_DEC = 2'b01;
  localparam logic [1:0] c_OP_ACC = 2'b10;

  logic [BITS-1:0] r_acc;
  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_EW-1:0] r_last;          // last popped entry, shown while empty
  logic [c_PW-1:0] r_wptr;
  logic [c_PW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;

  logic [BITS-1:0] w_src;
  logic [BITS:0]   w_sum;
  logic [BITS:0]   w_dif;
  logic [BITS-1:0] w_r;
  logic [BITS-1:0] w_res;
  logic            w_co;
  logic            w_v;
  logic [c_EW-1:0] w_entry;
  logic [c_EW-1:0] w_head;
  logic            w_push;
  logic            w_pop;
  logic [c_PW-1:0] w_wptr_nxt;
  logic [c_PW-1:0] w_rptr_nxt;

  // ---------------------------------------------------------------- datapath
  assign w_src = (bus.op == c_OP_ACC) ? r_acc : (bus.sel ? bus.B : bus.A);
  assign w_sum = {1'b0, w_src} + {1'b0, bus.step};
  assign w_dif = {1'b0, w_src} - {1'b0, bus.step};

  always_comb begin
    w_r  = '0;
    w_co = 1'b0;
    w_v  = 1'b0;
    case (bus.op)
      c_OP_INC, c_OP_ACC: begin
        w_r  = w_sum[BITS-1:0];
        w_co = w_sum[BITS];
        // unsigned step: only a positive operand can overflow upward
        w_v  = ~w_src[BITS-1] & w_sum[BITS-1];
      end
      c_OP_DEC: begin
        w_r  = w_dif[BITS-1:0];
        w_co = w_dif[BITS];     // top bit of the extended difference is the borrow
        w_v  = w_src[BITS-1] & ~w_dif[BITS-1];
      end
      default: begin
        w_r  = '0;
        w_co = 1'b0;
        w_v  = 1'b0;
      end
    endcase
  end

`ifdef INCDEC_SAT_EN
  always_comb begin
    w_res = w_r;
    if (w_v) begin
      w_res = (bus.op == c_OP_DEC) ? {1'b1, {(BITS-1){1'b0}}}
                                   : {1'b0, {(BITS-1){1'b1}}};
    end
  end
`else
  assign w_res = w_r;
`endif

  assign w_entry = {w_res, w_res[BITS-1], (w_res == '0), w_co, w_v};

  // ---------------------------------------------------------------- FIFO
  assign bus.out_valid = (r_count != '0);
  assign w_pop         = bus.out_valid & bus.out_ready;
  // a simultaneous pop frees a slot, so a full FIFO may still accept
  assign bus.in_ready  = (r_count < c_DEPTH) | w_pop;
  assign w_push        = bus.in_valid & bus.in_ready;

  assign w_wptr_nxt = (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
  assign w_rptr_nxt = (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_last  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= w_wptr_nxt;
        r_acc         <= w_res;
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= w_rptr_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = bus.out_valid ? r_mem[r_rptr] : r_last;
  assign bus.S  = w_head[c_EW-1:4];
  assign bus.N  = w_head[3];
  assign bus.Z  = w_head[2];
  assign bus.Co = w_head[1];
  assign bus.V  = w_head[0];

endmodule
`default_nettype wire

// File: doc/incdec_pipe.md
Name: incdec_pipe

Overview:
- Parametrised, registered increment/decrement/accumulate unit for the ALU datapath.
- Successor to the combinational single-step incrementer. Adds:
  - programmable step
  - decrement
  - an internal accumulator for chained counting
  - a 2-entry output buffer with valid/ready handshakes on both sides
- Sits between the ALU operand mux and the result writeback. Flags are registered alongside each result.

Parameters:
- BITS, 4, datapath width (signed two's complement), minimum 2.
- DEPTH, 2, output buffer entries, power of two, minimum 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- op  in  2  00 INC, 01 DEC, 10 ACC (source = accumulator), 11 CLR
- sel  in  1  source select for INC/DEC: 0 = A, 1 = B
- A  in  BITS  signed operand A
- B  in  BITS  signed operand B
- step  in  BITS  unsigned step magnitude
- out_valid  out  1  result present at buffer head
- out_ready  in  1  consumer takes result this cycle
- S  out  BITS  signed result at buffer head
- N  out  1  S[BITS-1]
- Z  out  1  S == 0
- Co  out  1  carry (INC/ACC) or borrow (DEC)
- V  out  1  signed overflow

Behaviour:
- Reset (async, rst_n=0):
  - buffer empty; out_valid=0
  - S, N, Z, Co, V = 0
  - accumulator = 0
  - in_ready=1 one cycle after deassertion and onward
- Accept: in_valid & in_ready at a rising edge.
- in_ready = (count < DEPTH) | (out_valid & out_ready). Simultaneous pop allows a push into a full buffer.
- Source by op:
  - INC/DEC: sel ? B : A
  - ACC: accumulator register
  - CLR: no source
- Arithmetic, computed in BITS+1 bits in the accept cycle:
  - INC/ACC: R = src + step. Co = bit BITS of the unsigned sum. V = (src[msb]==0) & (R[msb]==1). step is unsigned, so only positive overflow is possible.
  - DEC: R = src - step. Co = 1 when unsigned src < step (borrow). V = (src[msb]==1) & (R[msb]==0).
  - CLR: R=0, Co=0, V=0.
  - Z and N are derived from the final stored R.
  - Default (wrap): R = low BITS bits.
- Accumulator:
  - Loads R on every accepted op. CLR loads 0.
  - Back-to-back ACC accepts chain without bubbles: the second accept sees the first's result.
- Latency: a result is written into the buffer at the accept edge. out_valid rises on the same edge, so the result is visible the cycle after accept.
- Buffer:
  - FIFO order.
  - Head fields S/N/Z/Co/V are held stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready.
  - Empty: S and flags hold their last popped values; out_valid=0.
  - Push and pop in the same cycle: count unchanged, order preserved, including at count=DEPTH.
- Pointers wrap modulo DEPTH.
- Inputs are ignored when in_valid=0 or in_ready=0; the accumulator is unchanged.
- Reset mid-operation: all buffered results are discarded and the accumulator clears immediately (asynchronously).

Optional Feature:
- Macro INCDEC_SAT_EN.
- Defined: when V=1, R clamps to 2^(BITS-1)-1 (INC/ACC) or -2^(BITS-1) (DEC). V is still reported as 1, Co is computed as in wrap mode, and the accumulator loads the clamped value.
- Undefined: wrap-around results as above, with no clamp logic synthesised.

Test Plan:
- BITS=4, INC, sel=0, A=0111, step=1 -> S=1000, V=1, N=1, Co=0, Z=0; with INCDEC_SAT_EN -> S=0111, V=1.
- INC, sel=1, B=1111, step=1 -> S=0000, Co=1, Z=1, V=0.
- DEC, A=1000, step=1 -> S=0111, V=1, Co=0; with INCDEC_SAT_EN -> S=1000. DEC, A=0000, step=3 -> S=1101, Co=1, N=1.
- CLR, then 3 back-to-back ACC with step=2 -> outputs 0000, 0010, 0100, 0110 in order; accumulator ends at 0110.
- out_ready=0 with DEPTH=2: third request sees in_ready=0 and the head is held stable. Assert out_ready with in_valid=1 -> push and pop in one cycle, count stays 2, FIFO order intact.
- rst_n pulsed low while 2 results are buffered -> out_valid=0 immediately, all outputs 0; a following ACC with step=1 -> S=0001.
